// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcode encodings,
// FSM states, instruction classes and the packed datapath strobe bundle.
package control_sequencer_pkg;

    localparam int OPC_W    = 5;
    localparam int ALU_OP_W = 5;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_HALT = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        CL_RTYPE = 4'd0,
        CL_IMM   = 4'd1,
        CL_LD    = 4'd2,
        CL_LDI   = 4'd3,
        CL_ST    = 4'd4,
        CL_BR    = 4'd5,
        CL_JR    = 4'd6,
        CL_NOP   = 4'd7,
        CL_HALT  = 4'd8
    } opc_class_e;

    typedef struct packed {
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic ba_out;
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic c_out;
        logic con_in;
        logic read;
        logic write;
    } ctrl_t;

    // Immediate forms reuse the ALU function of their register-form sibling.
    function automatic logic [ALU_OP_W-1:0] imm_alu_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_opcode_classifier.sv
// Combinational opcode-to-class decode; unknown opcodes fall into the nop class.
module opcode_classifier
    import control_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output opc_class_e       opc_class_o
);

    // Map each opcode onto the execute sequence it follows.
    always_comb begin
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:   opc_class_o = CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:          opc_class_o = CL_IMM;
            OP_LD:                             opc_class_o = CL_LD;
            OP_LDI:                            opc_class_o = CL_LDI;
            OP_ST:                             opc_class_o = CL_ST;
            OP_BR:                             opc_class_o = CL_BR;
            OP_JR:                             opc_class_o = CL_JR;
            OP_HALT:                           opc_class_o = CL_HALT;
            OP_NOP:                            opc_class_o = CL_NOP;
            default:                           opc_class_o = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch, per-class execute sequences, memory wait with
// timeout, and halt on opcode, external stop or memory fault.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)
(
    input  logic                clk,
    input  logic                clr,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                con_ff,
    input  logic                mem_ready,
    input  logic                stop,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Cout,
    output logic                CONin,
    output logic                Read,
    output logic                Write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                mem_fault
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_e              state_q, state_d, state_step_s;
    logic                boot_q, boot_d;
    logic                stop_q, stop_d;
    logic                fault_q, fault_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    opc_class_e          opc_class_s;
    logic                mem_step_s;
    logic                enter_t0_s;
    ctrl_t               ctrl_s;
    logic [ALU_OP_W-1:0] alu_op_s;

    opcode_classifier u_classifier (
        .opcode_i    (opcode),
        .opc_class_o (opc_class_s)
    );

    // boot_q holds strobes low after clr until the first edge presents T0.
    assign mem_step_s = (state_q == ST_T1) ||
                        ((state_q == ST_T6) && (opc_class_s == CL_LD)) ||
                        ((state_q == ST_T7) && (opc_class_s == CL_ST));

    // Step sequencing ignoring stop and timeout.
    always_comb begin
        state_step_s = state_q;
        enter_t0_s   = 1'b0;
        if (boot_q) begin
            enter_t0_s = 1'b1;
        end else begin
            case (state_q)
                ST_T0: state_step_s = ST_T1;
                ST_T1: begin
                    if (mem_ready) state_step_s = ST_T2;
                    else           state_step_s = ST_T1;
                end
                ST_T2: state_step_s = ST_T3;
                ST_T3: begin
                    case (opc_class_s)
                        CL_HALT:        state_step_s = ST_HALT;
                        CL_JR, CL_NOP:  enter_t0_s   = 1'b1;
                        default:        state_step_s = ST_T4;
                    endcase
                end
                ST_T4: state_step_s = ST_T5;
                ST_T5: begin
                    if ((opc_class_s == CL_LD) || (opc_class_s == CL_ST) || (opc_class_s == CL_BR))
                        state_step_s = ST_T6;
                    else
                        enter_t0_s = 1'b1;
                end
                ST_T6: begin
                    case (opc_class_s)
                        CL_LD:   state_step_s = mem_ready ? ST_T7 : ST_T6;
                        CL_ST:   state_step_s = ST_T7;
                        default: enter_t0_s   = 1'b1;
                    endcase
                end
                ST_T7: begin
                    if ((opc_class_s == CL_ST) && !mem_ready) state_step_s = ST_T7;
                    else                                      enter_t0_s   = 1'b1;
                end
                ST_HALT: state_step_s = ST_HALT;
                default: state_step_s = ST_HALT;
            endcase
        end
    end

    // Timeout overrides everything; stop is honoured only at the T0 boundary.
    always_comb begin
        boot_d  = 1'b0;
        fault_d = fault_q;
        stop_d  = stop_q | (stop & (state_q != ST_HALT));
        state_d = state_step_s;
        if (mem_step_s && !mem_ready) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = '0;
        end
        if (mem_step_s && !mem_ready && (wait_q == WAIT_LAST)) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
        end else if (enter_t0_s) begin
            state_d = (stop_q || stop) ? ST_HALT : ST_T0;
            stop_d  = 1'b0;
        end else begin
            state_d = state_step_s;
        end
    end

    // State, stop latch, sticky fault and wait counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_T0;
            boot_q  <= 1'b1;
            stop_q  <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            stop_q  <= stop_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    // Moore strobe decode of the registered step; opcode matters only from T3.
    always_comb begin
        ctrl_s   = '0;
        alu_op_s = '0;
        if (boot_q) begin
            ctrl_s = '0;
        end else begin
            case (state_q)
                ST_T0: begin
                    ctrl_s.pc_out = 1'b1; ctrl_s.mar_in = 1'b1;
                    ctrl_s.inc_pc = 1'b1; ctrl_s.z_in   = 1'b1;
                end
                ST_T1: begin
                    ctrl_s.zlow_out = 1'b1; ctrl_s.read = 1'b1; ctrl_s.mdr_in = 1'b1;
                    ctrl_s.pc_in    = (wait_q == '0);
                end
                ST_T2: begin
                    ctrl_s.mdr_out = 1'b1; ctrl_s.ir_in = 1'b1;
                end
                ST_T3: begin
                    case (opc_class_s)
                        CL_RTYPE, CL_IMM: begin
                            ctrl_s.grb = 1'b1; ctrl_s.rout = 1'b1; ctrl_s.y_in = 1'b1;
                        end
                        CL_LD, CL_LDI, CL_ST: begin
                            ctrl_s.grb = 1'b1; ctrl_s.ba_out = 1'b1; ctrl_s.y_in = 1'b1;
                        end
                        CL_BR: begin
                            ctrl_s.gra = 1'b1; ctrl_s.rout = 1'b1; ctrl_s.con_in = 1'b1;
                        end
                        CL_JR: begin
                            ctrl_s.gra = 1'b1; ctrl_s.rout = 1'b1; ctrl_s.pc_in = 1'b1;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                ST_T4: begin
                    case (opc_class_s)
                        CL_RTYPE: begin
                            ctrl_s.grc = 1'b1; ctrl_s.rout = 1'b1; ctrl_s.z_in = 1'b1;
                            alu_op_s   = opcode;
                        end
                        CL_IMM: begin
                            ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1;
                            alu_op_s     = imm_alu_op(opcode);
                        end
                        CL_LD, CL_LDI, CL_ST: begin
                            ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1;
                            alu_op_s     = OP_ADD;
                        end
                        CL_BR: begin
                            ctrl_s.pc_out = 1'b1; ctrl_s.y_in = 1'b1;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                ST_T5: begin
                    case (opc_class_s)
                        CL_RTYPE, CL_IMM, CL_LDI: begin
                            ctrl_s.zlow_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rin = 1'b1;
                        end
                        CL_LD, CL_ST: begin
                            ctrl_s.zlow_out = 1'b1; ctrl_s.mar_in = 1'b1;
                        end
                        CL_BR: begin
                            ctrl_s.c_out = 1'b1; ctrl_s.z_in = 1'b1;
                            alu_op_s     = OP_ADD;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                ST_T6: begin
                    case (opc_class_s)
                        CL_LD: begin
                            ctrl_s.read = 1'b1; ctrl_s.mdr_in = 1'b1;
                        end
                        CL_ST: begin
                            ctrl_s.gra = 1'b1; ctrl_s.rout = 1'b1; ctrl_s.mdr_in = 1'b1;
                        end
                        CL_BR: begin
                            ctrl_s.zlow_out = 1'b1; ctrl_s.pc_in = con_ff;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                ST_T7: begin
                    case (opc_class_s)
                        CL_LD: begin
                            ctrl_s.mdr_out = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rin = 1'b1;
                        end
                        CL_ST:   ctrl_s.write = 1'b1;
                        default: ctrl_s = '0;
                    endcase
                end
                default: ctrl_s = '0;
            endcase
        end
    end

    assign Gra       = ctrl_s.gra;
    assign Grb       = ctrl_s.grb;
    assign Grc       = ctrl_s.grc;
    assign Rin       = ctrl_s.rin;
    assign Rout      = ctrl_s.rout;
    assign BAout     = ctrl_s.ba_out;
    assign PCout     = ctrl_s.pc_out;
    assign PCin      = ctrl_s.pc_in;
    assign IncPC     = ctrl_s.inc_pc;
    assign MARin     = ctrl_s.mar_in;
    assign MDRin     = ctrl_s.mdr_in;
    assign MDRout    = ctrl_s.mdr_out;
    assign IRin      = ctrl_s.ir_in;
    assign Yin       = ctrl_s.y_in;
    assign Zin       = ctrl_s.z_in;
    assign Zlowout   = ctrl_s.zlow_out;
    assign Cout      = ctrl_s.c_out;
    assign CONin     = ctrl_s.con_in;
    assign Read      = ctrl_s.read;
    assign Write     = ctrl_s.write;
    assign alu_op    = alu_op_s;
    assign run       = (state_q != ST_HALT);
    assign mem_fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: each stimulus cycle queues the expected strobe set; a monitor
// on the falling edge pops and compares.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clr, con_ff, mem_ready, stop;
    logic [4:0] opcode;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
    logic MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write;
    logic [4:0] alu_op;
    logic       run, mem_fault;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode), .con_ff(con_ff),
        .mem_ready(mem_ready), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write),
        .alu_op(alu_op), .run(run), .mem_fault(mem_fault)
    );

    localparam logic [19:0] Z0    = 20'h00000;
    localparam logic [19:0] GRA   = 20'h80000;
    localparam logic [19:0] GRB   = 20'h40000;
    localparam logic [19:0] GRC   = 20'h20000;
    localparam logic [19:0] RIN   = 20'h10000;
    localparam logic [19:0] ROUT  = 20'h08000;
    localparam logic [19:0] BAOUT = 20'h04000;
    localparam logic [19:0] PCOUT = 20'h02000;
    localparam logic [19:0] PCIN  = 20'h01000;
    localparam logic [19:0] INCPC = 20'h00800;
    localparam logic [19:0] MARIN = 20'h00400;
    localparam logic [19:0] MDRIN = 20'h00200;
    localparam logic [19:0] MDROUT= 20'h00100;
    localparam logic [19:0] IRIN  = 20'h00080;
    localparam logic [19:0] YIN   = 20'h00040;
    localparam logic [19:0] ZIN   = 20'h00020;
    localparam logic [19:0] ZLOW  = 20'h00010;
    localparam logic [19:0] COUT  = 20'h00008;
    localparam logic [19:0] CONIN = 20'h00004;
    localparam logic [19:0] READ  = 20'h00002;
    localparam logic [19:0] WRITE = 20'h00001;

    localparam logic [19:0] F0  = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [19:0] F1  = ZLOW | PCIN | READ | MDRIN;
    localparam logic [19:0] F1W = ZLOW | READ | MDRIN;
    localparam logic [19:0] F2  = MDROUT | IRIN;

    localparam logic [4:0] A_ADD = 5'b00011;
    localparam logic [4:0] A_AND = 5'b00101;

    typedef struct packed {
        logic [7:0]  tag;
        logic [19:0] stb;
        logic [4:0]  alu;
        logic        care;
        logic        rn;
        logic        fl;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tag_r  = 8'd0;
    logic [19:0] obs;

    assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
                  MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write};

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (obs !== mon_e.stb || run !== mon_e.rn || mem_fault !== mon_e.fl ||
                (mon_e.care && alu_op !== mon_e.alu)) begin
                errors++;
                $display("FAIL step%0d: strobes=%05h run=%b fault=%b alu=%05b, expected strobes=%05h run=%b fault=%b alu=%05b",
                         mon_e.tag, obs, run, mem_fault, alu_op,
                         mon_e.stb, mon_e.rn, mon_e.fl, mon_e.alu);
            end
        end
    end

    task automatic cyc(input logic mr, input logic [19:0] s, input logic [4:0] a,
                       input logic care, input logic rn, input logic fl);
        exp_t e;
        mem_ready = mr;
        e.tag = tag_r; e.stb = s; e.alu = a; e.care = care; e.rn = rn; e.fl = fl;
        sb_q.push_back(e);
        tag_r = tag_r + 8'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic c(input logic mr, input logic [19:0] s);
        cyc(mr, s, 5'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ca(input logic [19:0] s, input logic [4:0] a);
        cyc(1'b1, s, a, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic ch(input logic fl);
        cyc(1'b1, Z0, 5'd0, 1'b0, 1'b0, fl);
    endtask

    // Junk opcode during fetch proves T0..T2 ignore it.
    task automatic fetch(input logic [4:0] op);
        opcode = 5'b11011;
        c(1'b1, F0);
        c(1'b1, F1);
        c(1'b1, F2);
        opcode = op;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        c(1'b1, Z0);
        clr = 1'b0;
        c(1'b1, Z0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; opcode = 5'd0; con_ff = 1'b0; mem_ready = 1'b0; stop = 1'b0;
        @(posedge clk);
        #1;
        c(1'b1, Z0);
        do_reset();

        // add R1,R2,R3
        fetch(5'b00011);
        c(1'b1, GRB | ROUT | YIN);
        ca(GRC | ROUT | ZIN, A_ADD);
        c(1'b1, ZLOW | GRA | RIN);

        // ld with three wait cycles in T6
        fetch(5'b00000);
        c(1'b1, GRB | BAOUT | YIN);
        ca(COUT | ZIN, A_ADD);
        c(1'b1, ZLOW | MARIN);
        for (int i = 0; i < 3; i++) c(1'b0, READ | MDRIN);
        c(1'b1, READ | MDRIN);
        c(1'b1, MDROUT | GRA | RIN);

        // br not taken, then taken
        con_ff = 1'b0;
        fetch(5'b10011);
        c(1'b1, GRA | ROUT | CONIN);
        c(1'b1, PCOUT | YIN);
        ca(COUT | ZIN, A_ADD);
        c(1'b1, ZLOW);
        con_ff = 1'b1;
        fetch(5'b10011);
        c(1'b1, GRA | ROUT | CONIN);
        c(1'b1, PCOUT | YIN);
        ca(COUT | ZIN, A_ADD);
        c(1'b1, ZLOW | PCIN);
        con_ff = 1'b0;

        // andi, ldi, jr, and an unassigned opcode run as nop
        fetch(5'b01101);
        c(1'b1, GRB | ROUT | YIN);
        ca(COUT | ZIN, A_AND);
        c(1'b1, ZLOW | GRA | RIN);
        fetch(5'b00001);
        c(1'b1, GRB | BAOUT | YIN);
        ca(COUT | ZIN, A_ADD);
        c(1'b1, ZLOW | GRA | RIN);
        fetch(5'b10100);
        c(1'b1, GRA | ROUT | PCIN);
        fetch(5'b01111);
        c(1'b1, Z0);

        // stop pulsed in T4 of add: instruction completes, then HALT
        fetch(5'b00011);
        c(1'b1, GRB | ROUT | YIN);
        stop = 1'b1;
        ca(GRC | ROUT | ZIN, A_ADD);
        stop = 1'b0;
        c(1'b1, ZLOW | GRA | RIN);
        stop = 1'b1;
        ch(1'b0);
        ch(1'b0);
        stop = 1'b0;
        ch(1'b0);
        do_reset();

        // mem_ready stuck low in T1: timeout after 15 cycles
        c(1'b1, F0);
        c(1'b0, F1);
        for (int i = 0; i < 14; i++) c(1'b0, F1W);
        ch(1'b1);
        ch(1'b1);
        ch(1'b1);
        do_reset();

        // st with clr asserted in the middle of T6
        fetch(5'b00010);
        c(1'b1, GRB | BAOUT | YIN);
        ca(COUT | ZIN, A_ADD);
        c(1'b1, ZLOW | MARIN);
        mem_ready = 1'b1;
        begin
            exp_t e;
            e.tag = tag_r; e.stb = GRA | ROUT | MDRIN; e.alu = 5'd0;
            e.care = 1'b0; e.rn = 1'b1; e.fl = 1'b0;
            sb_q.push_back(e);
            tag_r = tag_r + 8'd1;
        end
        @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        checks++;
        if (obs !== Z0 || run !== 1'b1) begin
            errors++;
            $display("FAIL clr_async: strobes=%05h run=%b, expected strobes=%05h run=1", obs, run, Z0);
        end
        @(posedge clk);
        #1;
        c(1'b1, Z0);
        clr = 1'b0;
        c(1'b1, Z0);

        // full st with one Write wait cycle
        fetch(5'b00010);
        c(1'b1, GRB | BAOUT | YIN);
        ca(COUT | ZIN, A_ADD);
        c(1'b1, ZLOW | MARIN);
        c(1'b1, GRA | ROUT | MDRIN);
        c(1'b0, WRITE);
        c(1'b1, WRITE);

        // halt opcode
        fetch(5'b11011);
        c(1'b1, Z0);
        ch(1'b0);
        ch(1'b0);

        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
